// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-macro signals around the instruction memory arbiter
interface imem_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic [31:0] l_addr;
    logic [7:0]  l_wdata;
    logic        l_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: fetch-priority arbiter with loader anti-starvation for a single-port instruction memory
module imem_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input logic          clk,
    input logic          reset,
    imem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  lat_cnt;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [7:0]  wdata_q;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        l_pri, f_win, l_win, cap;

    // grants are gated by reset so every output drops to its reset value asynchronously
    always_comb begin
        l_pri    = bus.l_req && wait_cnt == 8'(MAX_WAIT);
        f_win    = !reset && state == IDLE && bus.f_req && !l_pri;
        l_win    = !reset && state == IDLE && bus.l_req && !f_win;
        cap      = state == RD_WAIT && lat_cnt == 4'd0;
        state_nx = f_win ? RD_WAIT : cap ? IDLE : state;
    end

    assign bus.f_gnt     = f_win;
    assign bus.l_gnt     = l_win;
    assign bus.mem_en    = f_win || l_win;
    assign bus.mem_we    = l_win;
    assign bus.mem_addr  = f_win ? bus.f_addr : l_win ? bus.l_addr : addr_q;
    assign bus.mem_wdata = l_win ? bus.l_wdata : wdata_q;
    assign bus.busy      = state == RD_WAIT;
    assign bus.f_rvalid  = rvalid_q;
    assign bus.f_rdata   = rdata_q;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // read latency, starvation counter, held memory address/data and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt  <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            lat_cnt  <= f_win ? 4'(RD_LAT - 1) : (state == RD_WAIT && lat_cnt != 4'd0) ? lat_cnt - 4'd1 : lat_cnt;
            wait_cnt <= (bus.l_req && !l_win) ? (wait_cnt == 8'(MAX_WAIT) ? wait_cnt : wait_cnt + 8'd1) : 8'd0;
            addr_q   <= bus.mem_addr;
            wdata_q  <= bus.mem_wdata;
            rdata_q  <= cap ? bus.mem_rdata : rdata_q;
            rvalid_q <= cap;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized fetch/loader traffic against a cycle-count reference model
module tb_imem_arbiter;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    imem_arbiter_if bus();

    imem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0]  ref_mem [64];
    logic [7:0]  mac     [64];
    int          cyc, free_cyc, rv_cyc, mac_cyc, wc;
    logic [31:0] last_addr, rdata, pend_word, mac_word;
    logic [7:0]  last_wdata;
    logic        last_fg, last_lg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [5:0] b;
        b = a[5:0];
        return {ref_mem[b], ref_mem[b + 6'd1], ref_mem[b + 6'd2], ref_mem[b + 6'd3]};
    endfunction

    function automatic logic [31:0] mac_word_at(input logic [31:0] a);
        logic [5:0] b;
        b = a[5:0];
        return {mac[b], mac[b + 6'd1], mac[b + 6'd2], mac[b + 6'd3]};
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_f_gnt"},     bus.f_gnt,     0);
        check({pfx, "_l_gnt"},     bus.l_gnt,     0);
        check({pfx, "_mem_en"},    bus.mem_en,    0);
        check({pfx, "_mem_we"},    bus.mem_we,    0);
        check({pfx, "_busy"},      bus.busy,      0);
        check({pfx, "_f_rvalid"},  bus.f_rvalid,  0);
        check({pfx, "_f_rdata"},   bus.f_rdata,   0);
        check({pfx, "_mem_addr"},  bus.mem_addr,  0);
        check({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic one_cycle(input logic fr, input logic [31:0] fa, input logic lr,
                             input logic [31:0] la, input logic [7:0] lw, input bit rst_pulse);
        logic        idle, eg_f, eg_l;
        logic [31:0] ea;
        logic [7:0]  ew;
        @(negedge clk);
        bus.f_req     = fr;
        bus.f_addr    = fa;
        bus.l_req     = lr;
        bus.l_addr    = la;
        bus.l_wdata   = lw;
        bus.mem_rdata = (cyc == mac_cyc) ? mac_word : $urandom;
        if (rst_pulse) begin
            #1 reset = 1'b1;
            #1 check_zero("rst");
            bus.f_req = 1'b0;
            bus.l_req = 1'b0;
            #1 reset = 1'b0;
            free_cyc   = 0;
            rv_cyc     = -1;
            mac_cyc    = -1;
            wc         = 0;
            last_addr  = '0;
            last_wdata = '0;
            rdata      = '0;
            last_fg    = 1'b0;
            last_lg    = 1'b0;
        end else begin
            #1;
            idle = cyc >= free_cyc;
            eg_f = idle && fr && !(lr && wc == MAX_WAIT);
            eg_l = idle && lr && !eg_f;
            if (cyc == rv_cyc) rdata = pend_word;
            ea = eg_f ? fa : eg_l ? la : last_addr;
            ew = eg_l ? lw : last_wdata;
            check("f_gnt",     bus.f_gnt,     eg_f);
            check("l_gnt",     bus.l_gnt,     eg_l);
            check("mem_en",    bus.mem_en,    eg_f || eg_l);
            check("mem_we",    bus.mem_we,    eg_l);
            check("busy",      bus.busy,      !idle);
            check("f_rvalid",  bus.f_rvalid,  cyc == rv_cyc);
            check("f_rdata",   bus.f_rdata,   rdata);
            check("mem_addr",  bus.mem_addr,  ea);
            check("mem_wdata", bus.mem_wdata, ew);
            if (eg_f) begin
                free_cyc  = cyc + RD_LAT + 1;
                rv_cyc    = free_cyc;
                pend_word = ref_word(fa);
            end
            if (eg_l) ref_mem[la[5:0]] = lw;
            wc         = (lr && !eg_l) ? (wc < MAX_WAIT ? wc + 1 : wc) : 0;
            last_addr  = ea;
            last_wdata = ew;
            last_fg    = eg_f;
            last_lg    = eg_l;
            if (bus.mem_en && !bus.mem_we) begin
                mac_cyc  = cyc + RD_LAT;
                mac_word = mac_word_at(bus.mem_addr);
            end
            if (bus.mem_en && bus.mem_we) mac[bus.mem_addr[5:0]] = bus.mem_wdata;
        end
        cyc++;
    endtask

    initial begin
        logic        fr, lr, both, rp;
        logic [31:0] fa, la;
        logic [7:0]  lw;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'($urandom);
            mac[i]     = ref_mem[i];
        end
        ref_mem[0] = 8'h4C; ref_mem[1] = 8'h00; ref_mem[2] = 8'h00; ref_mem[3] = 8'h46;
        for (int i = 0; i < 4; i++) mac[i] = ref_mem[i];
        cyc = 0; free_cyc = 0; rv_cyc = -1; mac_cyc = -1; wc = 0;
        last_addr = '0; last_wdata = '0; rdata = '0; pend_word = '0; mac_word = '0;
        last_fg = 1'b0; last_lg = 1'b0;
        bus.f_req = 1'b0; bus.f_addr = '0; bus.l_req = 1'b0; bus.l_addr = '0;
        bus.l_wdata = '0; bus.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        #1 check_zero("init");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) one_cycle(i < 1, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0);
        for (int i = 0; i < 4; i++) one_cycle(1'b0, 32'h0, 1'b1, 32'h8, 8'hBA, 1'b0);
        fa = $urandom; la = $urandom; lw = 8'($urandom); fr = 1'b0; lr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            both = i >= 1000 && i < 1600;
            if (!fr || last_fg) fa = $urandom;
            if (!lr || last_lg) begin la = $urandom; lw = 8'($urandom); end
            fr = both ? 1'b1 : $urandom_range(0, 99) < 50;
            lr = both ? 1'b1 : $urandom_range(0, 99) < 40;
            rp = (free_cyc > cyc) && $urandom_range(0, 39) == 0;
            one_cycle(fr, fa, lr, la, lw, rp);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port byte-addressable instruction memory between two requesters: the fetch stage (32-bit big-endian word reads) and the program loader (byte writes).
- Fetch has fixed priority over the loader.
- A starvation counter forces a loader grant after MAX_WAIT lost cycles.
- The block sits between fetch/loader and the memory macro, and sequences the multi-cycle read latency with one outstanding operation at a time.

Parameters:
RD_LAT, 2, memory read latency in cycles from the mem_en issue cycle to mem_rdata valid (legal range 1..15)
MAX_WAIT, 4, consecutive denied loader-request cycles before the loader takes priority (legal range 1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
f_req  input  1  fetch read request, held until f_gnt
f_addr  input  32  fetch byte address; word = bytes addr..addr+3, big-endian
f_gnt  output  1  fetch request accepted this cycle
f_rvalid  output  1  one-cycle pulse; f_rdata valid
f_rdata  output  32  read word, registered
l_req  input  1  loader write request, held until l_gnt
l_addr  input  32  loader byte address
l_wdata  input  8  loader write byte
l_gnt  output  1  loader write performed this cycle
mem_en  output  1  memory access strobe
mem_we  output  1  1 = byte write, 0 = word read
mem_addr  output  32  memory byte address
mem_wdata  output  8  memory write byte
mem_rdata  input  32  memory read word, valid RD_LAT cycles after issue
busy  output  1  read outstanding (FSM in RD_WAIT)

Behaviour:
- Reset values:
  - FSM = IDLE; lat_cnt = 0; wait_cnt = 0.
  - f_gnt, l_gnt, f_rvalid, mem_en, mem_we, busy = 0.
  - f_rdata, mem_addr, mem_wdata = 0.
- FSM states: IDLE, RD_WAIT.
- IDLE arbitration (combinational grant; mem_* driven in the same cycle):
  - Loader has priority when l_req && wait_cnt == MAX_WAIT.
  - Otherwise fetch wins if f_req, else the loader wins if l_req.
  - Fetch win: f_gnt = 1, mem_en = 1, mem_we = 0, mem_addr = f_addr. Go to RD_WAIT with lat_cnt = RD_LAT-1.
  - Loader win: l_gnt = 1, mem_en = 1, mem_we = 1, mem_addr = l_addr, mem_wdata = l_wdata. Stay in IDLE; the write completes in one cycle.
  - No requests: all strobes 0; mem_addr/mem_wdata hold their previous values.
- RD_WAIT:
  - No grants; mem_en = 0; busy = 1.
  - lat_cnt decrements each cycle.
  - In the cycle where lat_cnt == 0, mem_rdata is valid: capture it into f_rdata, pulse f_rvalid on the next cycle, and return to IDLE.
  - Effective fetch latency: f_gnt in cycle N, f_rvalid in cycle N+RD_LAT+1.
  - The earliest next grant is cycle N+RD_LAT+1, the same cycle as f_rvalid.
- wait_cnt (8-bit, saturating at MAX_WAIT):
  - Increments in every cycle where l_req = 1 and l_gnt = 0, including RD_WAIT cycles.
  - Clears on l_gnt or when l_req = 0.
- Simultaneous f_req and l_req with wait_cnt < MAX_WAIT: fetch wins and wait_cnt increments.
- Requests arriving during RD_WAIT are held by the requester and arbitrated on return to IDLE.
- Dropping a request without a grant is allowed; no state is retained except wait_cnt clearing.
- f_rdata holds its value until the next capture.
- Reset asserted mid-read: the operation is discarded immediately.
  - No f_rvalid for the lost read.
  - The memory result arriving later is ignored because the FSM is in IDLE.
- Address arithmetic: 32-bit passthrough, no alignment checks; unaligned fetch addresses go to memory unchanged.

Test Plan:
- Reset, then f_req=1, f_addr=0x0, memory word 0x4C000046, RD_LAT=2 -> f_gnt at cycle 1; mem_en=1, mem_we=0, mem_addr=0; busy=1 for 2 cycles; f_rvalid at cycle 4 with f_rdata=0x4C000046.
- l_req only, l_addr=0x8, l_wdata=0xBA -> l_gnt, mem_en, mem_we same cycle with mem_addr=0x8, mem_wdata=0xBA; l_req held 3 more cycles -> 4 writes back-to-back, busy never asserted.
- f_req and l_req held continuously, MAX_WAIT=4 -> fetch grants keep coming until wait_cnt reaches 4; next IDLE grants the loader; wait_cnt returns to 0; fetch is granted again in the following cycle.
- RD_LAT=1, f_req held with f_addr stepping 0x0, 0x4, 0x8 -> f_gnt every 2 cycles; f_rvalid coincides with the next f_gnt; words returned in order.
- Reset pulsed during the RD_WAIT cycle of a read at 0x4 -> no f_rvalid; all outputs return to reset values asynchronously; the first grant after release is clean.
- f_req raised for 1 cycle during RD_WAIT, then dropped -> no grant; no mem_en; FSM returns to IDLE idle.
